// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, palette table and color index names used by
// the color driver and its timing generator.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOT = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOT = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef logic [3:0]  color_idx_t;
    typedef logic [11:0] rgb12_t;

    localparam color_idx_t COLOR_BLACK   = 4'd0;
    localparam color_idx_t COLOR_WHITE   = 4'd1;
    localparam color_idx_t COLOR_RED     = 4'd2;
    localparam color_idx_t COLOR_GREEN   = 4'd3;
    localparam color_idx_t COLOR_BLUE    = 4'd4;
    localparam color_idx_t COLOR_YELLOW  = 4'd5;
    localparam color_idx_t COLOR_CYAN    = 4'd6;
    localparam color_idx_t COLOR_MAGENTA = 4'd7;
    localparam color_idx_t COLOR_GREY    = 4'd8;

    // Entry 0 sits in the least significant slot; codes 8..15 all map to grey.
    localparam logic [15:0][11:0] PALETTE = {
        12'h888, 12'h888, 12'h888, 12'h888,
        12'h888, 12'h888, 12'h888, 12'h888,
        12'hF0F, 12'h0FF, 12'hFF0, 12'h00F,
        12'h0F0, 12'hF00, 12'hFFF, 12'h000
    };

    function automatic rgb12_t palette_lookup(input color_idx_t idx);
        return PALETTE[idx];
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical pixel counters with sync, active-video and frame-start
// decode; sync/de are registered one pixel behind the counters.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_ce,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          active,
    output logic          first_px,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic h_last;
    logic v_last;
    logic hs_on;
    logic vs_on;

    always_comb begin
        h_last   = (h == H_LAST);
        v_last   = (v == V_LAST);
        active   = (h < H_ACT) && (v < V_ACT);
        first_px = (h == '0) && (v == '0);
        hs_on    = (h >= HS_BEG) && (h < HS_END);
        vs_on    = (v >= VS_BEG) && (v < VS_END);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h           <= '0;
            v           <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            // Pulses on the strobe that wraps the last pixel back to (0,0).
            frame_start <= pix_ce && h_last && v_last;
            if (pix_ce) begin
                hsync <= hs_on ? SYNC_POL : ~SYNC_POL;
                vsync <= vs_on ? SYNC_POL : ~SYNC_POL;
                de    <= active;
                if (h_last) begin
                    h <= '0;
                    v <= v_last ? '0 : v + 1'b1;
                end else begin
                    h <= h + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_color_driver.sv
// 640x480 VGA output stage: latches the color code once per frame, draws an
// optional white border and drives registered palette RGB alongside sync/de.
module vga_color_driver
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int BORDER   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    input  logic [3:0]  color,
    output logic [11:0] rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start
);

    localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          active;
    logic          first_px;
    logic          on_border;
    color_idx_t    color_q;
    color_idx_t    color_cur;
    color_idx_t    idx;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .pix_ce      (pix_ce),
        .h           (h),
        .v           (v),
        .active      (active),
        .first_px    (first_px),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .frame_start (frame_start)
    );

    if (BORDER > 0) begin : g_border
        assign on_border = (h <  HW'(BORDER))            ||
                           (h >= HW'(H_ACTIVE - BORDER)) ||
                           (v <  VW'(BORDER))            ||
                           (v >= VW'(V_ACTIVE - BORDER));
    end else begin : g_no_border
        assign on_border = 1'b0;
    end

    // Pixel (0,0) is drawn on the same edge that latches the code, so the
    // live input is forwarded straight into the lookup there.
    always_comb begin
        color_cur = first_px ? color : color_q;
        idx       = on_border ? COLOR_WHITE : color_cur;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color_q <= COLOR_BLACK;
            rgb     <= 12'h000;
        end else if (pix_ce) begin
            if (first_px)
                color_q <= color;
            rgb <= active ? palette_lookup(idx) : 12'h000;
        end
    end

endmodule
